thread_lsu: RTL and testbench

//   Per-thread load/store unit. Consumes the rs/rt operands that the thread's register file

---
 rtl/gpu_pkg.sv | 22 ++
 rtl/lsu_watchdog.sv | 25 ++
 rtl/thread_lsu.sv | 154 +++++++++++++++
 tb/tb_thread_lsu.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared encodings for the core scheduler FSM and the per-thread LSU state.
package gpu_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/lsu_watchdog.sv
// WAITING-cycle watchdog: expired is high in the LIMIT-th counted cycle.
// Counter saturates at LIMIT so a stalled thread cannot wrap and re-fire.
module lsu_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] r_cnt;

    assign expired = count && (r_cnt == W'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (count && (r_cnt != W'(LIMIT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/thread_lsu.sv
// Per-thread load/store unit: turns LDR/STR into a valid/ready memory transaction.
// Optional watchdog abort on stalled memory is built when LSU_TIMEOUT_EN is defined.
module thread_lsu
    import gpu_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int ADDR_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);
    lsu_state_t           r_state,  w_state_nx;
    logic                 r_is_read, w_is_read_nx;
    logic                 r_rv, w_rv_nx;
    logic                 r_wv, w_wv_nx;
    logic [ADDR_BITS-1:0] r_raddr, w_raddr_nx;
    logic [ADDR_BITS-1:0] r_waddr, w_waddr_nx;
    logic [DATA_BITS-1:0] r_wdata, w_wdata_nx;
    logic [DATA_BITS-1:0] r_out, w_out_nx;
    logic                 w_expired;
    logic                 w_err_set;

`ifdef LSU_TIMEOUT_EN
    logic r_err;

    lsu_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (enable && (r_state == LSU_REQUESTING)),
        .count   (enable && (r_state == LSU_WAITING)),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (enable && w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign lsu_error = r_err;
`else
    assign w_expired = 1'b0;
    assign lsu_error = 1'b0;
`endif

    always_comb begin
        w_state_nx   = r_state;
        w_is_read_nx = r_is_read;
        w_rv_nx      = r_rv;
        w_wv_nx      = r_wv;
        w_raddr_nx   = r_raddr;
        w_waddr_nx   = r_waddr;
        w_wdata_nx   = r_wdata;
        w_out_nx     = r_out;
        w_err_set    = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                if ((core_state == CORE_REQUEST) &&
                    (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                    w_state_nx   = LSU_REQUESTING;
                    w_is_read_nx = decoded_mem_read_enable;
                end
            end
            LSU_REQUESTING: begin
                if (r_is_read) begin
                    w_raddr_nx = rs[ADDR_BITS-1:0];
                    w_rv_nx    = 1'b1;
                end else begin
                    w_waddr_nx = rs[ADDR_BITS-1:0];
                    w_wdata_nx = rt;
                    w_wv_nx    = 1'b1;
                end
                w_state_nx = LSU_WAITING;
            end
            LSU_WAITING: begin
                // Ready beats a same-cycle timeout.
                if (r_is_read && mem_read_ready) begin
                    w_out_nx   = mem_read_data;
                    w_rv_nx    = 1'b0;
                    w_state_nx = LSU_DONE;
                end else if (!r_is_read && mem_write_ready) begin
                    w_wv_nx    = 1'b0;
                    w_state_nx = LSU_DONE;
                end else if (w_expired) begin
                    w_rv_nx    = 1'b0;
                    w_wv_nx    = 1'b0;
                    w_err_set  = 1'b1;
                    w_state_nx = LSU_DONE;
                    if (r_is_read) begin
                        w_out_nx = '1;
                    end
                end
            end
            LSU_DONE: begin
                if (core_state == CORE_UPDATE) begin
                    w_state_nx = LSU_IDLE;
                end
            end
            default: w_state_nx = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= LSU_IDLE;
            r_is_read <= 1'b0;
            r_rv      <= 1'b0;
            r_wv      <= 1'b0;
            r_raddr   <= '0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_out     <= '0;
        end else if (enable) begin
            r_state   <= w_state_nx;
            r_is_read <= w_is_read_nx;
            r_rv      <= w_rv_nx;
            r_wv      <= w_wv_nx;
            r_raddr   <= w_raddr_nx;
            r_waddr   <= w_waddr_nx;
            r_wdata   <= w_wdata_nx;
            r_out     <= w_out_nx;
        end
    end

    assign mem_read_valid    = r_rv;
    assign mem_read_address  = r_raddr;
    assign mem_write_valid   = r_wv;
    assign mem_write_address = r_waddr;
    assign mem_write_data    = r_wdata;
    assign lsu_state         = r_state;
    assign lsu_out           = r_out;
endmodule

// File: tb/tb_thread_lsu.sv
// Directed bench for thread_lsu: vector table of full transactions plus reset/enable/timeout sequences.
module tb_thread_lsu;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       rd_en, wr_en;
    logic [7:0] rs, rt;
    logic       mem_read_valid, mem_read_ready;
    logic [7:0] mem_read_address, mem_read_data;
    logic       mem_write_valid, mem_write_ready;
    logic [7:0] mem_write_address, mem_write_data;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;
    logic       lsu_error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    thread_lsu #(
        .DATA_BITS      (8),
        .ADDR_BITS      (8),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .core_state               (core_state),
        .decoded_mem_read_enable  (rd_en),
        .decoded_mem_write_enable (wr_en),
        .rs                       (rs),
        .rt                       (rt),
        .mem_read_valid           (mem_read_valid),
        .mem_read_address         (mem_read_address),
        .mem_read_ready           (mem_read_ready),
        .mem_read_data            (mem_read_data),
        .mem_write_valid          (mem_write_valid),
        .mem_write_address        (mem_write_address),
        .mem_write_data           (mem_write_data),
        .mem_write_ready          (mem_write_ready),
        .lsu_state                (lsu_state),
        .lsu_out                  (lsu_out),
        .lsu_error                (lsu_error)
    );

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] rs;
        logic [7:0] rt;
        int         dly;
        logic [7:0] rdata;
        logic       exp_rv;
        logic       exp_wv;
        logic [7:0] exp_addr;
        logic [7:0] exp_wdata;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // IDLE -> REQUESTING -> WAITING; leaves the bench one cycle into WAITING.
    task automatic start_txn(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        core_state = 3'b011;
        rd_en = rd; wr_en = wr; rs = a; rt = d;
        step();
        chk("requesting", 32'(lsu_state), 32'd1);
        core_state = 3'b100;
        rd_en = 1'b0; wr_en = 1'b0;
        step();
        chk("waiting", 32'(lsu_state), 32'd2);
    endtask

    task automatic finish_update(input logic [7:0] exp_out);
        core_state = 3'b100;
        step();
        chk("done_hold", 32'(lsu_state), 32'd3);
        core_state = 3'b110;
        step();
        chk("idle_after_update", 32'(lsu_state), 32'd0);
        chk("out_after_update", 32'(lsu_out), 32'(exp_out));
        core_state = 3'b000;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'h2A, 8'h00, 2, 8'h5C, 1'b1, 1'b0, 8'h2A, 8'h00, 8'h5C};
        vecs[1] = '{1'b0, 1'b1, 8'h10, 8'h99, 0, 8'h00, 1'b0, 1'b1, 8'h10, 8'h99, 8'h5C};
        vecs[2] = '{1'b1, 1'b1, 8'h44, 8'h12, 1, 8'hA7, 1'b1, 1'b0, 8'h44, 8'h00, 8'hA7};
        vecs[3] = '{1'b0, 1'b1, 8'hFF, 8'h00, 3, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h00, 8'hA7};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 8'h00, 0, 8'h3C, 1'b1, 1'b0, 8'h00, 8'h00, 8'h3C};

        reset = 1'b1; enable = 1'b0; core_state = 3'b000;
        rd_en = 1'b0; wr_en = 1'b0; rs = 8'h00; rt = 8'h00;
        mem_read_ready = 1'b0; mem_read_data = 8'h00; mem_write_ready = 1'b0;
        step(); step();
        chk("rst_state", 32'(lsu_state), 32'd0);
        chk("rst_rv", 32'(mem_read_valid), 32'd0);
        chk("rst_wv", 32'(mem_write_valid), 32'd0);
        chk("rst_raddr", 32'(mem_read_address), 32'd0);
        chk("rst_waddr", 32'(mem_write_address), 32'd0);
        chk("rst_wdata", 32'(mem_write_data), 32'd0);
        chk("rst_out", 32'(lsu_out), 32'd0);
        chk("rst_err", 32'(lsu_error), 32'd0);
        reset = 1'b0;

        // Never enabled: a request must not move anything.
        core_state = 3'b011; rd_en = 1'b1;
        step();
        chk("disabled_state", 32'(lsu_state), 32'd0);
        chk("disabled_rv", 32'(mem_read_valid), 32'd0);
        enable = 1'b1; core_state = 3'b000; rd_en = 1'b0;
        step();

        // REQUEST with no memory op stays IDLE.
        core_state = 3'b011;
        step();
        chk("noop_idle", 32'(lsu_state), 32'd0);
        core_state = 3'b000;

        for (int i = 0; i < 5; i++) begin
            start_txn(vecs[i].rd, vecs[i].wr, vecs[i].rs, vecs[i].rt);
            for (int c = 0; c <= vecs[i].dly; c++) begin
                chk($sformatf("v%0d_rv", i), 32'(mem_read_valid), 32'(vecs[i].exp_rv));
                chk($sformatf("v%0d_wv", i), 32'(mem_write_valid), 32'(vecs[i].exp_wv));
                if (vecs[i].exp_rv) begin
                    chk($sformatf("v%0d_raddr", i), 32'(mem_read_address), 32'(vecs[i].exp_addr));
                end else begin
                    chk($sformatf("v%0d_waddr", i), 32'(mem_write_address), 32'(vecs[i].exp_addr));
                    chk($sformatf("v%0d_wdata", i), 32'(mem_write_data), 32'(vecs[i].exp_wdata));
                end
                if (c == vecs[i].dly) begin
                    mem_read_ready  = vecs[i].exp_rv;
                    mem_write_ready = vecs[i].exp_wv;
                    mem_read_data   = vecs[i].rdata;
                end else begin
                    chk($sformatf("v%0d_still_wait", i), 32'(lsu_state), 32'd2);
                end
                step();
            end
            mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = 8'hEE;
            chk($sformatf("v%0d_done", i), 32'(lsu_state), 32'd3);
            chk($sformatf("v%0d_rv_drop", i), 32'(mem_read_valid), 32'd0);
            chk($sformatf("v%0d_wv_drop", i), 32'(mem_write_valid), 32'd0);
            chk($sformatf("v%0d_out", i), 32'(lsu_out), 32'(vecs[i].exp_out));
            finish_update(vecs[i].exp_out);
        end

        // Late ready after completion must be ignored.
        mem_read_ready = 1'b1; mem_read_data = 8'h11;
        step();
        chk("stray_ready_out", 32'(lsu_out), 32'h3C);
        chk("stray_ready_state", 32'(lsu_state), 32'd0);
        mem_read_ready = 1'b0;

        // Reset in WAITING.
        start_txn(1'b1, 1'b0, 8'h77, 8'h00);
        chk("pre_reset_rv", 32'(mem_read_valid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_reset_rv", 32'(mem_read_valid), 32'd0);
        chk("mid_reset_state", 32'(lsu_state), 32'd0);
        chk("mid_reset_out", 32'(lsu_out), 32'd0);
        chk("mid_reset_addr", 32'(mem_read_address), 32'd0);
        core_state = 3'b000;
        step();

        // enable=0 in WAITING with ready high: frozen until re-enabled.
        start_txn(1'b1, 1'b0, 8'h33, 8'h00);
        enable = 1'b0; mem_read_ready = 1'b1; mem_read_data = 8'h77;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("frozen_state", 32'(lsu_state), 32'd2);
            chk("frozen_rv", 32'(mem_read_valid), 32'd1);
            chk("frozen_out", 32'(lsu_out), 32'd0);
        end
        enable = 1'b1;
        step();
        mem_read_ready = 1'b0;
        chk("resume_state", 32'(lsu_state), 32'd3);
        chk("resume_out", 32'(lsu_out), 32'h77);
        finish_update(8'h77);

`ifdef LSU_TIMEOUT_EN
        start_txn(1'b1, 1'b0, 8'h55, 8'h00);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("to_still_valid", 32'(mem_read_valid), 32'd1);
            chk("to_no_err_yet", 32'(lsu_error), 32'd0);
        end
        step();
        chk("to_rv_drop", 32'(mem_read_valid), 32'd0);
        chk("to_state", 32'(lsu_state), 32'd3);
        chk("to_out", 32'(lsu_out), 32'hFF);
        chk("to_err", 32'(lsu_error), 32'd1);
        finish_update(8'hFF);
        start_txn(1'b1, 1'b0, 8'h56, 8'h00);
        mem_read_ready = 1'b1; mem_read_data = 8'h21;
        step();
        mem_read_ready = 1'b0;
        chk("good_after_to_out", 32'(lsu_out), 32'h21);
        chk("err_sticky", 32'(lsu_error), 32'd1);
        finish_update(8'h21);
`else
        chk("err_tied", 32'(lsu_error), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
